// File: rtl/data_read_pkg.sv
// Shared definitions for the LVDS capture sequencer and the capture buffer it feeds.
package data_read_pkg;

    localparam int DATA_READ_ADDR_W = 9;
    localparam int DATA_READ_DEPTH  = 512;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    function automatic logic state_is_busy(input state_t st);
        return (st == ST_ARM) || (st == ST_CAPTURE);
    endfunction

endpackage

// File: rtl/data_read_edge_det.sv
// Rising-edge detector for the capture trigger; the edge output is suppressed while clr is high.
module data_read_edge_det (
    input  logic LVDS_CLK,
    input  logic LVDS_RST,
    input  logic clr,
    input  logic trig,
    output logic trig_rise
);

    logic trig_d;

    // trig_d keeps tracking trig while cleared, so a level already high at arm time never fires
    always_ff @(posedge LVDS_CLK) begin
        if (LVDS_RST) begin
            trig_d <= 1'b0;
        end else begin
            trig_d <= trig;
        end
    end

    assign trig_rise = trig & ~trig_d & ~clr;

endmodule

// File: rtl/data_read_capture_ctrl.sv
// Capture sequencer: arms on start, optionally waits for a trigger edge, then writes
// len_q words into the capture buffer and reports done / aborted / start_err.
//
// state   | meaning
// IDLE    | waiting for start
// ARM     | waiting for trig rising edge
// CAPTURE | one buffer write per cycle, wr_addr 0..len_q-1
// DONE    | capture complete, done held until done_ack
module data_read_capture_ctrl
    import data_read_pkg::*;
#(
    parameter int ADDR_W = DATA_READ_ADDR_W,
    parameter int DEPTH  = DATA_READ_DEPTH
) (
    input  logic              LVDS_CLK,
    input  logic              LVDS_RST,
    input  logic              start,
    input  logic              abort,
    input  logic              trig_en,
    input  logic              trig,
    input  logic [ADDR_W:0]   cfg_len,
    input  logic              done_ack,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              wr_en,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic              start_err,
    output logic [ADDR_W:0]   words
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    state_t          state;
    logic [ADDR_W:0] len_q;
    logic [ADDR_W:0] len_eff;
    logic            last_wr;
    logic            trig_rise;

    data_read_edge_det u_edge_det (
        .LVDS_CLK  (LVDS_CLK),
        .LVDS_RST  (LVDS_RST),
        .clr       (state != ST_ARM),
        .trig      (trig),
        .trig_rise (trig_rise)
    );

    assign len_eff = ((cfg_len == '0) || (cfg_len > DEPTH_L)) ? DEPTH_L : cfg_len;
    assign last_wr = ({1'b0, wr_addr} == (len_q - 1'b1));

    always_ff @(posedge LVDS_CLK) begin
        if (LVDS_RST) begin
            state     <= ST_IDLE;
            len_q     <= '0;
            wr_addr   <= '0;
            wr_en     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
            start_err <= 1'b0;
            words     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        len_q     <= len_eff;
                        aborted   <= 1'b0;
                        start_err <= 1'b0;
                        words     <= '0;
                        wr_addr   <= '0;
                        busy      <= 1'b1;
                        if (trig_en) begin
                            state <= ST_ARM;
                        end else begin
                            state <= ST_CAPTURE;
                            wr_en <= 1'b1;
                        end
                    end
                end
                ST_ARM: begin
                    if (start) start_err <= 1'b1;
                    if (abort) begin
                        state   <= ST_IDLE;
                        busy    <= 1'b0;
                        aborted <= 1'b1;
                    end else if (trig_rise) begin
                        state   <= ST_CAPTURE;
                        wr_en   <= 1'b1;
                        wr_addr <= '0;
                    end
                end
                ST_CAPTURE: begin
                    if (start) start_err <= 1'b1;
                    // the write issued this cycle counts even when it is the abort cycle
                    words <= words + 1'b1;
                    if (abort) begin
                        state   <= ST_IDLE;
                        busy    <= 1'b0;
                        wr_en   <= 1'b0;
                        wr_addr <= '0;
                        aborted <= 1'b1;
                    end else if (last_wr) begin
                        state   <= ST_DONE;
                        busy    <= 1'b0;
                        wr_en   <= 1'b0;
                        wr_addr <= '0;
                        done    <= 1'b1;
                    end else begin
                        wr_addr <= wr_addr + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (start) start_err <= 1'b1;
                    if (done_ack) begin
                        state <= ST_IDLE;
                        done  <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_read_capture_ctrl.sv
// Randomized bench for data_read_capture_ctrl: each run's waveform is predicted from its timeline.
module tb_data_read_capture_ctrl;

    localparam int AW    = 9;
    localparam int DEPTH = 512;

    logic          LVDS_CLK = 1'b0;
    logic          LVDS_RST;
    logic          start, abort, trig_en, trig, done_ack;
    logic [AW:0]   cfg_len;
    logic [AW-1:0] wr_addr;
    logic          wr_en, busy, done, aborted, start_err;
    logic [AW:0]   words;

    int checks   = 0;
    int failures = 0;

    always #5 LVDS_CLK = ~LVDS_CLK;

    data_read_capture_ctrl #(.ADDR_W(AW), .DEPTH(DEPTH)) dut (
        .LVDS_CLK  (LVDS_CLK),
        .LVDS_RST  (LVDS_RST),
        .start     (start),
        .abort     (abort),
        .trig_en   (trig_en),
        .trig      (trig),
        .cfg_len   (cfg_len),
        .done_ack  (done_ack),
        .wr_addr   (wr_addr),
        .wr_en     (wr_en),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted),
        .start_err (start_err),
        .words     (words)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge LVDS_CLK);
        #1;
    endtask

    task automatic check_all(input int e_wr_en, input int e_addr, input int e_busy, input int e_done,
                             input int e_words, input int e_ab, input int e_se);
        check("wr_en",     32'(wr_en),     32'(e_wr_en));
        check("wr_addr",   32'(wr_addr),   32'(e_addr));
        check("busy",      32'(busy),      32'(e_busy));
        check("done",      32'(done),      32'(e_done));
        check("words",     32'(words),     32'(e_words));
        check("aborted",   32'(aborted),   32'(e_ab));
        check("start_err", 32'(start_err), 32'(e_se));
    endtask

    function automatic int eff_len(input int c);
        return (c == 0 || c > DEPTH) ? DEPTH : c;
    endfunction

    // start is driven in relative cycle 0; the whole run is predicted from a few event times
    task automatic run_scenario(input int force_len, input int force_trig);
        int cl, len, use_trig, hi0, d, c0, cap, last_busy, a, end_idle, ab_max, r;
        int do_abort, ab, do_sp, s, ack_start, stray_ack, sa, ab_in_done;
        r = $urandom_range(0, 7);
        if (force_len >= 0)  cl = force_len;
        else if (r == 0)     cl = 0;
        else if (r == 1)     cl = $urandom_range(513, 1023);
        else if (r == 2)     cl = $urandom_range(511, 512);
        else                 cl = $urandom_range(1, 40);
        len      = eff_len(cl);
        use_trig = (force_trig >= 0) ? force_trig : int'($urandom_range(0, 1));
        hi0      = $urandom_range(0, 1);
        d        = $urandom_range(2, 8);
        c0       = use_trig ? d + 1 : 1;
        ab_max   = c0 + len - 2;
        do_abort = (force_len < 0) && (ab_max >= 1) && ($urandom_range(0, 9) < 3);
        ab       = do_abort ? int'($urandom_range(1, ab_max)) : 0;
        last_busy = do_abort ? ab : c0 + len - 1;
        cap      = do_abort ? ((ab >= c0) ? ab - c0 + 1 : 0) : len;
        a        = c0 + len + int'($urandom_range(0, 3));
        end_idle = do_abort ? ab + 1 : a + 1;
        do_sp      = (force_len < 0) && ($urandom_range(0, 9) < 3);
        s          = $urandom_range(1, last_busy);
        ack_start  = !do_abort && ($urandom_range(0, 9) < 3);
        stray_ack  = $urandom_range(0, 9) < 3;
        sa         = $urandom_range(1, last_busy);
        ab_in_done = !do_abort && ($urandom_range(0, 1) == 1);

        for (int t = 0; t <= end_idle + 1; t++) begin
            if (t >= 1) begin
                int e_wr;
                e_wr = (t >= c0) && (t - c0 < cap);
                check_all(e_wr, e_wr ? t - c0 : 0, int'(t <= last_busy),
                          int'(!do_abort && t >= c0 + len && t <= a),
                          (t < c0) ? 0 : ((t - c0 < cap) ? t - c0 : cap),
                          int'(do_abort && t > ab),
                          int'((do_sp && t > s) || (ack_start && t > a)));
            end
            start    = (t == 0) || (do_sp && t == s) || (ack_start && t == a);
            abort    = (do_abort && t == ab) || (ab_in_done && t == a) || (t == end_idle);
            done_ack = (!do_abort && t == a) || (stray_ack && t == sa);
            trig     = use_trig ? ((t == 0) ? hi0[0] : (t >= d)) : 1'($urandom_range(0, 1));
            cfg_len  = (t == 0) ? (AW+1)'(cl) : (AW+1)'($urandom_range(0, 1023));
            trig_en  = (t == 0) ? use_trig[0] : 1'($urandom_range(0, 1));
            tick();
        end
        start = 1'b0; abort = 1'b0; done_ack = 1'b0;
    endtask

    initial begin
        LVDS_RST = 1'b1;
        start = 1'b0; abort = 1'b0; trig_en = 1'b0; trig = 1'b0; done_ack = 1'b0; cfg_len = '0;
        repeat (3) tick();
        check_all(0, 0, 0, 0, 0, 0, 0);
        LVDS_RST = 1'b0;
        tick();

        run_scenario(16, 0);
        run_scenario(16, 1);
        run_scenario(0, 0);
        run_scenario(600, 1);
        for (int i = 0; i < 30; i++) run_scenario(-1, -1);

        // reset in the middle of a capture
        start = 1'b1; trig_en = 1'b0; cfg_len = 11'd20;
        tick();
        start = 1'b0;
        repeat (5) tick();
        check("mid_busy", 32'(busy), 32'd1);
        LVDS_RST = 1'b1;
        tick();
        check_all(0, 0, 0, 0, 0, 0, 0);
        LVDS_RST = 1'b0;

        for (int i = 0; i < 20; i++) run_scenario(-1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
